// File: rtl/key_repeat_if.sv
// Held-key levels in, single-cycle game action pulses out.
// The game FSM side drives enable and keys; key_repeat drives the pulses.
interface key_repeat_if;
    logic enable;
    logic key_left;
    logic key_right;
    logic key_down;
    logic key_rotate;
    logic key_drop;
    logic move_left;
    logic move_right;
    logic move_down;
    logic rotate;
    logic hard_drop;

    modport master (
        output enable, key_left, key_right, key_down, key_rotate, key_drop,
        input  move_left, move_right, move_down, rotate, hard_drop
    );

    modport slave (
        input  enable, key_left, key_right, key_down, key_rotate, key_drop,
        output move_left, move_right, move_down, rotate, hard_drop
    );
endinterface

// File: rtl/key_repeat.sv
// Turns held keys into game action pulses: DAS/ARR for left/right,
// fixed-rate repeat for soft drop, and press-edge-only rotate/hard drop.
//
// state    | meaning
// H_IDLE   | no horizontal key active
// H_DAS    | initial move issued, waiting DAS_CYCLES for first repeat
// H_REPEAT | auto-repeating every ARR_CYCLES
module key_repeat #(
    parameter int unsigned DAS_CYCLES  = 16000000,
    parameter int unsigned ARR_CYCLES  = 5000000,
    parameter int unsigned SOFT_CYCLES = 5000000,
    parameter int unsigned CNT_W       = 32
) (
    input logic        clk,
    input logic        rst,
    key_repeat_if.slave bus
);
    typedef enum logic [1:0] {H_IDLE, H_DAS, H_REPEAT} h_state_t;
    typedef enum logic {DIR_L, DIR_R} dir_t;

    localparam logic [CNT_W-1:0] DAS_LAST  = CNT_W'(DAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] ARR_LAST  = CNT_W'(ARR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    h_state_t         h_state, h_state_nxt;
    dir_t             dir, dir_nxt;
    logic [CNT_W-1:0] h_cnt, h_cnt_nxt;
    logic             soft_active, soft_active_nxt;
    logic [CNT_W-1:0] soft_cnt, soft_cnt_nxt;

    logic prev_left, prev_right, prev_down, prev_rotate, prev_drop;
    logic left_q, right_q, down_q, rotate_q, drop_q;
    logic left_nxt, right_nxt, down_nxt, rotate_nxt, drop_nxt;

    logic edge_l, edge_r, edge_d, edge_rot, edge_drop;
    logic active_held, other_held, other_edge;
    logic go;
    dir_t go_dir;
    logic [CNT_W-1:0] h_last;

    always_comb begin
        // Edges are gated by enable, so keys held across an enable rise stay silent.
        edge_l    = bus.enable & bus.key_left   & ~prev_left;
        edge_r    = bus.enable & bus.key_right  & ~prev_right;
        edge_d    = bus.enable & bus.key_down   & ~prev_down;
        edge_rot  = bus.enable & bus.key_rotate & ~prev_rotate;
        edge_drop = bus.enable & bus.key_drop   & ~prev_drop;

        active_held = (dir == DIR_L) ? bus.key_left  : bus.key_right;
        other_held  = (dir == DIR_L) ? bus.key_right : bus.key_left;
        other_edge  = (dir == DIR_L) ? edge_r        : edge_l;
        h_last      = (h_state == H_DAS) ? DAS_LAST : ARR_LAST;

        h_state_nxt     = h_state;
        dir_nxt         = dir;
        h_cnt_nxt       = h_cnt;
        soft_active_nxt = soft_active;
        soft_cnt_nxt    = soft_cnt;
        left_nxt        = 1'b0;
        right_nxt       = 1'b0;
        down_nxt        = 1'b0;
        rotate_nxt      = edge_rot;
        drop_nxt        = edge_drop;
        go              = 1'b0;
        go_dir          = DIR_R;

        if (!bus.enable) begin
            h_state_nxt     = H_IDLE;
            h_cnt_nxt       = '0;
            soft_active_nxt = 1'b0;
            soft_cnt_nxt    = '0;
        end else begin
            case (h_state)
                H_IDLE: begin
                    if (edge_r) begin
                        go = 1'b1; go_dir = DIR_R;
                    end else if (edge_l) begin
                        go = 1'b1; go_dir = DIR_L;
                    end
                end
                default: begin
                    if (edge_r && edge_l) begin
                        go = 1'b1; go_dir = DIR_R;
                    end else if (other_edge || (!active_held && other_held)) begin
                        go = 1'b1; go_dir = (dir == DIR_L) ? DIR_R : DIR_L;
                    end else if (!active_held) begin
                        h_state_nxt = H_IDLE;
                        h_cnt_nxt   = '0;
                    end else if (h_cnt == h_last) begin
                        h_state_nxt = H_REPEAT;
                        h_cnt_nxt   = '0;
                        left_nxt    = (dir == DIR_L);
                        right_nxt   = (dir == DIR_R);
                    end else begin
                        h_cnt_nxt = h_cnt + CNT_ONE;
                    end
                end
            endcase

            if (go) begin
                h_state_nxt = H_DAS;
                dir_nxt     = go_dir;
                h_cnt_nxt   = '0;
                left_nxt    = (go_dir == DIR_L);
                right_nxt   = (go_dir == DIR_R);
            end

            if (edge_d) begin
                soft_active_nxt = 1'b1;
                soft_cnt_nxt    = '0;
                down_nxt        = 1'b1;
            end else if (soft_active && !bus.key_down) begin
                soft_active_nxt = 1'b0;
                soft_cnt_nxt    = '0;
            end else if (soft_active) begin
                if (soft_cnt == SOFT_LAST) begin
                    soft_cnt_nxt = '0;
                    down_nxt     = 1'b1;
                end else begin
                    soft_cnt_nxt = soft_cnt + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_state     <= H_IDLE;
            dir         <= DIR_L;
            h_cnt       <= '0;
            soft_active <= 1'b0;
            soft_cnt    <= '0;
            prev_left   <= 1'b0;
            prev_right  <= 1'b0;
            prev_down   <= 1'b0;
            prev_rotate <= 1'b0;
            prev_drop   <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            down_q      <= 1'b0;
            rotate_q    <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            h_state     <= h_state_nxt;
            dir         <= dir_nxt;
            h_cnt       <= h_cnt_nxt;
            soft_active <= soft_active_nxt;
            soft_cnt    <= soft_cnt_nxt;
            prev_left   <= bus.key_left;
            prev_right  <= bus.key_right;
            prev_down   <= bus.key_down;
            prev_rotate <= bus.key_rotate;
            prev_drop   <= bus.key_drop;
            left_q      <= left_nxt;
            right_q     <= right_nxt;
            down_q      <= down_nxt;
            rotate_q    <= rotate_nxt;
            drop_q      <= drop_nxt;
        end
    end

    assign bus.move_left  = left_q;
    assign bus.move_right = right_q;
    assign bus.move_down  = down_q;
    assign bus.rotate     = rotate_q;
    assign bus.hard_drop  = drop_q;
endmodule
